// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter in front of an 8N1 UART serializer.
// Requesters present a byte plus req and wait for a one-cycle grant. Only IDLE
// arbitrates, and the winner's byte is latched on the granting edge.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned COUNTER_LIMIT = 2813,
    parameter int unsigned IDX_W         = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   data_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic [IDX_W-1:0]       owner,
    output logic                   busy,
    output logic                   tx
);

    localparam int unsigned        CNT_W     = (COUNTER_LIMIT > 1) ? $clog2(COUNTER_LIMIT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(COUNTER_LIMIT - 1);
    localparam logic [IDX_W:0]     NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [IDX_W-1:0] last;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W:0]   cand;

    // Rotating-priority pick: scan last+1, last+2, ... (mod NUM_REQ). The
    // loop runs from the farthest offset down, so the nearest hit is the
    // one left in pick_idx.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, last} + (IDX_W + 1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (req[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Frame FSM with registered line, grant, owner and busy outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            last    <= LAST_RST;
            owner   <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            tx      <= 1'b1;
        end else begin
            grant <= '0;
            case (state)
                StIdle: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (pick_valid) begin
                        shreg <= data_in[{pick_idx, 3'b000} +: 8];
                        owner <= pick_idx;
                        last  <= pick_idx;
                        grant <= GRANT_ONE << pick_idx;
                        state <= StStart;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                StStart: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= StData;
                        tx      <= shreg[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StData: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= StStop;
                            tx    <= 1'b1;
                        end else begin
                            // Shift so the next bit is always shreg[0].
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StStop: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized requesters,
// all checked every cycle against a timeline model of the frame.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int L  = 4;
    localparam int IW = 2;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req;
    logic [8*NR-1:0]   data_in;
    logic [NR-1:0]     grant;
    logic [IW-1:0]     owner;
    logic              busy;
    logic              tx;

    logic              reset3;
    logic [2:0]        req3;
    logic [23:0]       data3;
    logic [2:0]        grant3;
    logic [1:0]        owner3;
    logic              busy3;
    logic              tx3;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    bit done3 = 0;
    bit cmp_en = 0;

    uart_tx_arbiter #(.NUM_REQ(NR), .COUNTER_LIMIT(L), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .grant(grant), .owner(owner), .busy(busy), .tx(tx)
    );

    uart_tx_arbiter #(.NUM_REQ(3), .COUNTER_LIMIT(L), .IDX_W(2)) dut3 (
        .clk(clk), .reset(reset3), .req(req3), .data_in(data3),
        .grant(grant3), .owner(owner3), .busy(busy3), .tx(tx3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: a frame is a timeline m_t = 0..10L-1 cycles since its grant;
    // -1 means the line is idle and the next edge may arbitrate.
    int         m_t     = -1;
    int         m_last  = NR - 1;
    int         m_owner = 0;
    logic [7:0] m_byte  = 8'h00;

    function automatic int pick_rr(input int last, input logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++) begin
            if (r[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t     <= -1;
            m_last  <= NR - 1;
            m_owner <= 0;
        end else if (m_t >= 0) begin
            m_t <= (m_t + 1 == 10 * L) ? -1 : m_t + 1;
        end else if (pick_rr(m_last, req) >= 0) begin
            m_t     <= 0;
            m_owner <= pick_rr(m_last, req);
            m_last  <= pick_rr(m_last, req);
            m_byte  <= data_in[8 * pick_rr(m_last, req) +: 8];
        end
    end

    function automatic logic exp_tx();
        int slot;
        if (m_t < 0) return 1'b1;
        slot = m_t / L;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_byte[slot - 1];
    endfunction

    function automatic logic [NR-1:0] exp_grant();
        logic [NR-1:0] one;
        one = 1;
        return (m_t == 0) ? (one << m_owner) : '0;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_grant", 32'(grant), 32'(exp_grant()));
            chk("m_busy", 32'(busy), 32'(m_t >= 0));
            chk("m_tx", 32'(tx), 32'(exp_tx()));
            chk("m_owner", 32'(owner), 32'(m_owner));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        req = '0;
        data_in = '0;
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (grant != '0) begin
                for (int i = 0; i < NR; i++) if (grant[i]) idx = i;
                return;
            end
        end
        n_chk++;
        n_err++;
        $display("FAIL grant_timeout: no grant within 200 cycles, one required");
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            if (!busy) return;
            @(negedge clk);
        end
        n_chk++;
        n_err++;
        $display("FAIL idle_timeout: busy still high after 200 cycles, low required");
    endtask

    task automatic rand_step();
        logic [NR-1:0] g;
        g = exp_grant();
        for (int i = 0; i < NR; i++) begin
            if (req[i] && g[i]) begin
                if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
                else data_in[8*i +: 8] = 8'($urandom);
            end else if (!req[i]) begin
                if ($urandom_range(19, 0) == 0) begin
                    req[i] = 1'b1;
                    data_in[8*i +: 8] = 8'($urandom);
                end
            end else if ($urandom_range(299, 0) == 0) begin
                req[i] = 1'b0;
            end
        end
    endtask

    // Three-requester instance: all requesting, order must be 0,1,2,0.
    initial begin
        int ng;
        int gi;
        ng = 0;
        wait (reset3 == 1'b1);
        wait (reset3 == 1'b0);
        for (int n = 0; n < 400 && ng < 4; n++) begin
            @(negedge clk);
            chk("t6_owner_range", 32'(owner3 < 2'd3), 32'd1);
            chk("t6_idle_tx", 32'(busy3 | tx3), 32'd1);
            if (grant3 != 3'b000) begin
                gi = -1;
                for (int i = 0; i < 3; i++) if (grant3[i]) gi = i;
                chk("t6_order", 32'(gi), 32'(ng % 3));
                ng++;
            end
        end
        chk("t6_grants", 32'(ng), 32'd4);
        done3 = 1'b1;
    end

    initial begin
        int         g;
        int         cnt;
        int         prev;
        logic [9:0] lvl;
        logic [7:0] rx;

        reset = 1'b0; reset3 = 1'b0; req = '0; data_in = '0;
        req3 = 3'b111; data3 = {8'h33, 8'h22, 8'h11};
        #1 reset = 1'b1; reset3 = 1'b1;
        #20 reset3 = 1'b0;
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        #1 reset = 1'b0;
        cmp_en = 1'b1;

        // Test 1: single byte 0x55 from requester 0.
        do_reset();
        data_in[7:0] = 8'h55;
        req = 4'b0001;
        wait_grant(g);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_owner", 32'(owner), 32'd0);
        req = '0;
        lvl = 10'b1010101010;
        cnt = 0;
        for (int n = 0; n < 100; n++) begin
            if (!busy) break;
            cnt++;
            if (n % 4 == 1) chk("t1_tx", 32'(tx), 32'(lvl[n / 4]));
            @(negedge clk);
        end
        chk("t1_busy_len", 32'(cnt), 32'd40);
        chk("t1_tx_idle", 32'(tx), 32'd1);

        // Test 2: all four held, loopback decode of each frame.
        do_reset();
        data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req = 4'b1111;
        prev = 0;
        for (int f = 0; f < 5; f++) begin
            wait_grant(g);
            chk("t2_order", 32'(g), 32'(f % 4));
            if (f > 0) chk("t2_spacing", 32'(cyc - prev), 32'd41);
            prev = cyc;
            if (f < 4) begin
                rx = 8'h00;
                for (int n = 1; n < 40; n++) begin
                    @(negedge clk);
                    if (n % 4 == 1 && n / 4 >= 1 && n / 4 <= 8) rx[n / 4 - 1] = tx;
                end
                chk("t2_rx_byte", 32'(rx), 32'(8'hA0 + f));
            end
        end
        req = '0;
        wait_idle();

        // Test 3: rotation after a grant to requester 2.
        do_reset();
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b0100;
        wait_grant(g);
        chk("t3_first", 32'(g), 32'd2);
        req = '0;
        repeat (10) @(negedge clk);
        req = 4'b1010;
        wait_grant(g);
        chk("t3_second", 32'(g), 32'd3);
        req = 4'b0010;
        wait_grant(g);
        chk("t3_third", 32'(g), 32'd1);
        req = '0;
        wait_idle();

        // Test 4: reset mid-DATA of 0xFF, then priority restarts at 0.
        do_reset();
        data_in[15:8] = 8'hFF;
        req = 4'b0010;
        wait_grant(g);
        chk("t4_grant", 32'(g), 32'd1);
        req = '0;
        repeat (18) @(negedge clk);
        chk("t4_busy_pre", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t4_async_tx", 32'(tx), 32'd1);
        chk("t4_async_busy", 32'(busy), 32'd0);
        chk("t4_async_grant", 32'(grant), 32'd0);
        chk("t4_async_owner", 32'(owner), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        data_in = {8'h00, 8'h5A, 8'h00, 8'hC3};
        req = 4'b0101;
        wait_grant(g);
        chk("t4_after_rst", 32'(grant), 32'h1);
        req = 4'b0100;
        wait_grant(g);
        chk("t4_next", 32'(g), 32'd2);
        req = '0;
        wait_idle();

        // Test 5: one-cycle glitch on req[1] while busy gets no grant.
        do_reset();
        data_in[7:0] = 8'h0F;
        req = 4'b0001;
        wait_grant(g);
        req = '0;
        repeat (5) @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        wait_idle();
        for (int n = 0; n < 3; n++) begin
            chk("t5_no_grant", 32'(grant), 32'd0);
            chk("t5_tx_high", 32'(tx), 32'd1);
            @(negedge clk);
        end

        // Randomized requesters following the hold-until-grant protocol.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rand_step();
        end
        req = '0;
        wait_idle();
        repeat (2) @(negedge clk);

        chk("t6_done", 32'(done3), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
